// File: rtl/spart_pkg.sv
// Shared definitions for the SPART echo driver: bus addresses, FSM states
// and the baud divisor helpers.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    localparam int unsigned BAUD_4800  = 4800;
    localparam int unsigned BAUD_9600  = 9600;
    localparam int unsigned BAUD_19200 = 19200;
    localparam int unsigned BAUD_38400 = 38400;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_PROG_LO,
        ST_PROG_HI,
        ST_RUN
    } state_t;

    function automatic logic [15:0] baud_div(input int unsigned clk_hz, input int unsigned baud);
        int unsigned q;
        q = clk_hz / (16 * baud);
        return q[15:0];
    endfunction

    function automatic logic [15:0] cfg_div(input int unsigned clk_hz, input logic [1:0] cfg);
        logic [15:0] d;
        case (cfg)
            2'b00:   d = baud_div(clk_hz, BAUD_4800);
            2'b01:   d = baud_div(clk_hz, BAUD_9600);
            2'b10:   d = baud_div(clk_hz, BAUD_19200);
            default: d = baud_div(clk_hz, BAUD_38400);
        endcase
        return d;
    endfunction

endpackage

// File: rtl/spart_echo_driver_if.sv
// Control/status side of the SPART bus; the bidirectional data bus stays a
// plain inout port on the driver.
interface spart_echo_driver_if;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;

    modport master (input rda, input tbr, output iocs, output iorw, output ioaddr);
    modport slave  (output rda, output tbr, input iocs, input iorw, input ioaddr);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; DEPTH must be a power
// of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end
endmodule

// File: rtl/spart_echo_driver.sv
// Programs the SPART baud divisor, then echoes received bytes back through a
// FIFO; reprograms whenever br_cfg changes.
module spart_echo_driver
    import spart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter bit          DROP_ON_FULL = 1'b0,
    parameter bit          UPCASE       = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [1:0]                        br_cfg,
    spart_echo_driver_if.master               bus,
    inout  wire  [7:0]                        databus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow
);
    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cfg_q;
    logic        rd_hold;
    logic        wr_hold;
    logic        rd_take;
    logic        wr_take;
    logic        push;
    logic        full;
    logic        empty;
    logic [7:0]  head;
    logic [7:0]  tx_byte;
    logic [7:0]  bus_out;
    logic [15:0] div_lo_src;
    logic [15:0] div_hi_src;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;

    // Low byte follows live br_cfg (sampled into cfg_q the same cycle) so the
    // high byte, taken from cfg_q, always matches it.
    assign div_lo_src = cfg_div(CLK_HZ, br_cfg);
    assign div_hi_src = cfg_div(CLK_HZ, cfg_q);
    assign tx_byte    = (UPCASE && head >= 8'h61 && head <= 8'h7A) ? head - 8'h20 : head;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (wr_take),
        .din   (databus),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            cfg_q    <= '0;
            rd_hold  <= 1'b0;
            wr_hold  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_hold <= rd_take;
            wr_hold <= wr_take;
            if (state == ST_PROG_LO) cfg_q <= br_cfg;
            if (rd_take && full) overflow <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        iocs      = 1'b0;
        iorw      = 1'b1;
        ioaddr    = ADDR_DATA;
        bus_out   = '0;
        rd_take   = 1'b0;
        wr_take   = 1'b0;
        push      = 1'b0;
        case (state)
            ST_INIT: state_nxt = ST_PROG_LO;
            ST_PROG_LO: begin
                iocs      = 1'b1;
                iorw      = 1'b0;
                ioaddr    = ADDR_DB_LO;
                bus_out   = div_lo_src[7:0];
                state_nxt = ST_PROG_HI;
            end
            ST_PROG_HI: begin
                iocs      = 1'b1;
                iorw      = 1'b0;
                ioaddr    = ADDR_DB_HI;
                bus_out   = div_hi_src[15:8];
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (br_cfg != cfg_q) begin
                    state_nxt = ST_PROG_LO;
                end else if (bus.rda && !rd_hold && (!full || DROP_ON_FULL)) begin
                    iocs    = 1'b1;
                    iorw    = 1'b1;
                    rd_take = 1'b1;
                    push    = !full;
                end else if (bus.tbr && !wr_hold && !empty) begin
                    iocs    = 1'b1;
                    iorw    = 1'b0;
                    bus_out = tx_byte;
                    wr_take = 1'b1;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign bus.iocs   = iocs;
    assign bus.iorw   = iorw;
    assign bus.ioaddr = ioaddr;
    assign databus    = (iocs && !iorw) ? bus_out : 8'hzz;
endmodule

// File: tb/tb_spart_echo_driver.sv
// Directed bench for spart_echo_driver: two instances (stalling+upcase and
// dropping) share stimulus except where their full behaviour diverges.
module tb_spart_echo_driver;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] br_cfg;
    logic       rda_a, rda_b, tbr_a, tbr_b;
    logic [7:0] rx_a, rx_b;
    wire  [7:0] databus_a;
    wire  [7:0] databus_b;
    logic [2:0] count_a, count_b;
    logic       overflow_a, overflow_b;
    int         n_checks = 0;
    int         n_pass = 0;

    spart_echo_driver_if a_if ();
    spart_echo_driver_if b_if ();

    assign a_if.rda = rda_a;
    assign a_if.tbr = tbr_a;
    assign b_if.rda = rda_b;
    assign b_if.tbr = tbr_b;
    // SPART side: the data register drives the bus only while it is being read
    assign databus_a = (a_if.iocs && a_if.iorw) ? rx_a : 8'hzz;
    assign databus_b = (b_if.iocs && b_if.iorw) ? rx_b : 8'hzz;

    spart_echo_driver #(
        .CLK_HZ       (100_000_000),
        .FIFO_DEPTH   (4),
        .DROP_ON_FULL (1'b0),
        .UPCASE       (1'b1)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .br_cfg     (br_cfg),
        .bus        (a_if),
        .databus    (databus_a),
        .fifo_count (count_a),
        .overflow   (overflow_a)
    );

    spart_echo_driver #(
        .CLK_HZ       (100_000_000),
        .FIFO_DEPTH   (4),
        .DROP_ON_FULL (1'b1),
        .UPCASE       (1'b0)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .br_cfg     (br_cfg),
        .bus        (b_if),
        .databus    (databus_b),
        .fifo_count (count_b),
        .overflow   (overflow_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rda;
        logic       tbr;
        logic [7:0] rx;
        logic       iocs;
        logic       iorw;
        logic [1:0] addr;
        logic [7:0] data;
        logic [2:0] cnt;
    } vec_t;

    vec_t vt [17];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic t, input logic [7:0] d);
        rda_a = r; rda_b = r;
        tbr_a = t; tbr_b = t;
        rx_a  = d; rx_b  = d;
    endtask

    // Checks both instances against one expectation; iorw/addr only matter
    // during an access, the data only during a write.
    task automatic expect_bus(input string name, input logic cs, input logic rw,
                              input logic [1:0] addr, input logic [7:0] data_a,
                              input logic [7:0] data_b);
        check({name, ".iocs_a"}, a_if.iocs, cs);
        check({name, ".iocs_b"}, b_if.iocs, cs);
        if (cs) begin
            check({name, ".iorw_a"}, a_if.iorw, rw);
            check({name, ".iorw_b"}, b_if.iorw, rw);
            check({name, ".addr_a"}, a_if.ioaddr, addr);
            check({name, ".addr_b"}, b_if.ioaddr, addr);
            if (!rw) begin
                check({name, ".data_a"}, databus_a, data_a);
                check({name, ".data_b"}, databus_b, data_b);
            end
        end
    endtask

    task automatic expect_count(input string name, input logic [2:0] c);
        check({name, ".cnt_a"}, count_a, c);
        check({name, ".cnt_b"}, count_b, c);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        set_in(1'b1, 1'b0, b);
        @(negedge clk);
        expect_bus("rx", 1'b1, 1'b1, 2'b00, 8'h00, 8'h00);
        next_cycle();
        set_in(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        expect_bus("rx_gap", 1'b0, 1'b1, 2'b00, 8'h00, 8'h00);
        next_cycle();
    endtask

    task automatic tx_pair(input string name, input logic [7:0] ea, input logic [7:0] eb);
        @(negedge clk);
        expect_bus(name, 1'b1, 1'b0, 2'b00, ea, eb);
        next_cycle();
        @(negedge clk);
        expect_bus({name, "_hold"}, 1'b0, 1'b1, 2'b00, 8'h00, 8'h00);
        next_cycle();
    endtask

    initial begin
        logic [7:0] up_in  [4];
        logic [7:0] up_out [4];
        int reads_a, reads_b, wr_a, wr_b;

        vt[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00, 3'd0};
        vt[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b10, 8'h8B, 3'd0};
        vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b11, 8'h02, 3'd0};
        vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00, 3'd0};
        vt[4]  = '{1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 2'b00, 8'h00, 3'd0};
        vt[5]  = '{1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 2'b00, 8'h00, 3'd1};
        vt[6]  = '{1'b1, 1'b0, 8'h42, 1'b1, 1'b1, 2'b00, 8'h00, 3'd1};
        vt[7]  = '{1'b1, 1'b0, 8'h42, 1'b0, 1'b1, 2'b00, 8'h00, 3'd2};
        vt[8]  = '{1'b1, 1'b0, 8'h43, 1'b1, 1'b1, 2'b00, 8'h00, 3'd2};
        vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00, 3'd3};
        vt[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 2'b00, 8'h41, 3'd3};
        vt[11] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00, 3'd2};
        vt[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 2'b00, 8'h42, 3'd2};
        vt[13] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00, 3'd1};
        vt[14] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 2'b00, 8'h43, 3'd1};
        vt[15] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00, 3'd0};
        vt[16] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00, 3'd0};

        up_in  = '{8'h61, 8'h7A, 8'h5B, 8'h7B};
        up_out = '{8'h41, 8'h5A, 8'h5B, 8'h7B};

        rst_n  = 1'b0;
        br_cfg = 2'b01;
        set_in(1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_bus("reset", 1'b0, 1'b1, 2'b00, 8'h00, 8'h00);
        check("reset.iorw_a", a_if.iorw, 1'b1);
        check("reset.addr_a", a_if.ioaddr, 2'b00);
        expect_count("reset", 3'd0);
        check("reset.ovf_a", overflow_a, 1'b0);
        check("reset.ovf_b", overflow_b, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Programming at 9600 baud, then a three-byte echo
        for (int i = 0; i < 17; i++) begin
            set_in(vt[i].rda, vt[i].tbr, vt[i].rx);
            @(negedge clk);
            expect_bus($sformatf("tbl%0d", i), vt[i].iocs, vt[i].iorw, vt[i].addr,
                       vt[i].data, vt[i].data);
            if (i == 0) check("tbl0.init_iorw", a_if.iorw, 1'b1);
            expect_count($sformatf("tbl%0d", i), vt[i].cnt);
            next_cycle();
        end

        // Case folding on instance a only
        for (int i = 0; i < 4; i++) rx_byte(up_in[i]);
        expect_count("up_filled", 3'd4);
        set_in(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) tx_pair($sformatf("up%0d", i), up_out[i], up_in[i]);
        expect_count("up_drained", 3'd0);
        set_in(1'b0, 1'b0, 8'h00);

        // 01 -> 00 reprogram, then 00 -> 11 with bytes buffered and tbr high
        br_cfg = 2'b00;
        @(negedge clk); expect_bus("rp0_gap", 1'b0, 1'b1, 2'b00, 8'h00, 8'h00); next_cycle();
        @(negedge clk); expect_bus("rp0_lo", 1'b1, 1'b0, 2'b10, 8'h16, 8'h16); next_cycle();
        @(negedge clk); expect_bus("rp0_hi", 1'b1, 1'b0, 2'b11, 8'h05, 8'h05); next_cycle();
        rx_byte(8'h11);
        rx_byte(8'h22);
        expect_count("rp1_buf", 3'd2);
        br_cfg = 2'b11;
        set_in(1'b0, 1'b1, 8'h00);
        @(negedge clk); expect_bus("rp1_gap", 1'b0, 1'b1, 2'b00, 8'h00, 8'h00); next_cycle();
        @(negedge clk); expect_bus("rp1_lo", 1'b1, 1'b0, 2'b10, 8'hA2, 8'hA2); next_cycle();
        @(negedge clk); expect_bus("rp1_hi", 1'b1, 1'b0, 2'b11, 8'h00, 8'h00);
        expect_count("rp1_kept", 3'd2);
        next_cycle();
        tx_pair("rp1_tx0", 8'h11, 8'h11);
        tx_pair("rp1_tx1", 8'h22, 8'h22);
        expect_count("rp1_empty", 3'd0);
        set_in(1'b0, 1'b0, 8'h00);

        // Reset asserted in the middle of a write
        rx_byte(8'h33);
        set_in(1'b0, 1'b1, 8'h00);
        @(negedge clk);
        expect_bus("mid_wr", 1'b1, 1'b0, 2'b00, 8'h33, 8'h33);
        #1 rst_n = 1'b0;
        #1;
        expect_bus("mid_rst", 1'b0, 1'b1, 2'b00, 8'h00, 8'h00);
        check("mid_rst.iorw_a", a_if.iorw, 1'b1);
        expect_count("mid_rst", 3'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); expect_bus("rr_init", 1'b0, 1'b1, 2'b00, 8'h00, 8'h00); next_cycle();
        @(negedge clk); expect_bus("rr_lo", 1'b1, 1'b0, 2'b10, 8'hA2, 8'hA2); next_cycle();
        @(negedge clk); expect_bus("rr_hi", 1'b1, 1'b0, 2'b11, 8'h00, 8'h00); next_cycle();
        @(negedge clk); expect_bus("rr_run", 1'b0, 1'b1, 2'b00, 8'h00, 8'h00);
        expect_count("rr_run", 3'd0);
        next_cycle();

        // Six bytes offered with tbr low: a stalls at four, b drops two
        reads_a = 0; reads_b = 0; wr_a = 0; wr_b = 0;
        tbr_a = 1'b0; tbr_b = 1'b0;
        for (int c = 0; c < 20; c++) begin
            rda_a = (reads_a < 6); rx_a = 8'h50 + 8'(reads_a);
            rda_b = (reads_b < 6); rx_b = 8'h50 + 8'(reads_b);
            @(negedge clk);
            if (a_if.iocs && a_if.iorw) reads_a++;
            if (b_if.iocs && b_if.iorw) reads_b++;
            next_cycle();
        end
        check("ovf.reads_a", reads_a, 4);
        check("ovf.reads_b", reads_b, 6);
        @(negedge clk);
        check("ovf.stall_rda", rda_a, 1'b1);
        check("ovf.stall_iocs", a_if.iocs, 1'b0);
        expect_count("ovf_full", 3'd4);
        check("ovf.flag_a", overflow_a, 1'b0);
        check("ovf.flag_b", overflow_b, 1'b1);
        next_cycle();

        tbr_a = 1'b1; tbr_b = 1'b1;
        for (int c = 0; c < 30; c++) begin
            rda_a = (reads_a < 6); rx_a = 8'h50 + 8'(reads_a);
            rda_b = (reads_b < 6); rx_b = 8'h50 + 8'(reads_b);
            @(negedge clk);
            if (a_if.iocs && a_if.iorw) reads_a++;
            if (b_if.iocs && b_if.iorw) reads_b++;
            if (a_if.iocs && !a_if.iorw) begin
                check($sformatf("drain_a%0d", wr_a), databus_a, 8'h50 + 8'(wr_a));
                wr_a++;
            end
            if (b_if.iocs && !b_if.iorw) begin
                check($sformatf("drain_b%0d", wr_b), databus_b, 8'h50 + 8'(wr_b));
                wr_b++;
            end
            next_cycle();
        end
        check("drain.reads_a", reads_a, 6);
        check("drain.writes_a", wr_a, 6);
        check("drain.writes_b", wr_b, 4);
        expect_count("drain_end", 3'd0);
        check("drain.flag_a", overflow_a, 1'b0);
        check("drain.flag_b_sticky", overflow_b, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
